// File: rtl/syn_ps_pkg.sv
// syn_ps_pkg: shared types and widths for the syn_ps_elastic pipeline stage.
package syn_ps_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } ps_state_e;

    localparam int PS_LEVEL_W    = 2;
    localparam int PS_PERF_CNT_W = 32;

endpackage

// File: rtl/syn_ps_elastic_perf_cnt.sv
// syn_ps_perf_cnt: saturating up-counter adding a small increment each cycle.
module syn_ps_perf_cnt
    import syn_ps_pkg::*;
#(
    parameter int W     = PS_PERF_CNT_W,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     cnt
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + (W+1)'(inc);
        cnt_d = sum[W] ? '1 : sum[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/syn_ps_elastic.sv
// syn_ps_elastic: valid/ready pipeline stage with a main + skid register pair.
// Optional perf counters are built when SYN_PS_PERF_CNT_EN is defined.
module syn_ps_elastic
    import syn_ps_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ZERO_ON_CLEAR = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [PS_LEVEL_W-1:0]    level
`ifdef SYN_PS_PERF_CNT_EN
    ,
    output logic [PS_PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PS_PERF_CNT_W-1:0] perf_drop_cnt
`endif
);

    ps_state_e                 state_q, state_d;
    logic                      in_ready_q, out_valid_q;
    logic [PS_LEVEL_W-1:0]     level_q;
    logic [DATA_W-1:0]         main_q, main_d, skid_q, skid_d;
    logic                      in_fire, out_fire, load_main, load_skid, move_skid;

    always_comb begin
        in_fire   = in_valid & in_ready_q;
        out_fire  = out_valid_q & out_ready;
        load_main = in_fire & ((state_q == EMPTY) | ((state_q == BUSY) & out_fire));
        load_skid = in_fire & (state_q == BUSY) & !out_fire;
        move_skid = (state_q == FULL) & out_fire;
        state_d   = clear                ? EMPTY :
                    (state_q == EMPTY)   ? (in_fire ? BUSY : EMPTY) :
                    (state_q == BUSY)    ? (load_skid ? FULL : (!in_fire & out_fire) ? EMPTY : BUSY) :
                                           (out_fire ? BUSY : FULL);
        main_d    = clear     ? ((ZERO_ON_CLEAR != 0) ? '0 : main_q) :
                    load_main ? in_data :
                    move_skid ? skid_q : main_q;
        skid_d    = clear     ? ((ZERO_ON_CLEAR != 0) ? '0 : skid_q) :
                    load_skid ? in_data : skid_q;
    end

    // Handshake outputs are decoded from the next state so they leave the flop directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            level_q     <= '0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= state_d != FULL;
            out_valid_q <= state_d != EMPTY;
            level_q     <= (state_d == FULL) ? 2'd2 : (state_d == BUSY) ? 2'd1 : 2'd0;
            main_q      <= main_d;
            skid_q      <= skid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign level     = level_q;

`ifdef SYN_PS_PERF_CNT_EN
    logic [1:0] stall_inc, drop_inc;

    // A beat leaving downstream on the flush cycle was delivered, not dropped.
    always_comb begin
        stall_inc = {1'b0, out_valid_q & !out_ready & !clear};
        drop_inc  = clear ? (level_q + {1'b0, in_fire} - {1'b0, out_fire}) : 2'd0;
    end

    syn_ps_perf_cnt #(.W(PS_PERF_CNT_W), .INC_W(2)) u_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .cnt   (perf_stall_cnt)
    );

    syn_ps_perf_cnt #(.W(PS_PERF_CNT_W), .INC_W(2)) u_drop (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop_inc),
        .cnt   (perf_drop_cnt)
    );
`endif

endmodule

// File: tb/tb_syn_ps_elastic.sv
// tb_syn_ps_elastic: directed self-checking bench for syn_ps_elastic.
module tb_syn_ps_elastic;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  level;
`ifdef SYN_PS_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_drop_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    syn_ps_elastic #(.DATA_W(32), .ZERO_ON_CLEAR(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .level          (level)
`ifdef SYN_PS_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
        compared++; if (level !== 2'd0) begin mismatched++; $display("FAIL reset_level got %0d exp 0", level); end
        compared++; if (out_data !== 32'h0) begin mismatched++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
        step();
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL stream_first_valid got %0h exp 1", out_valid); end
        compared++; if (out_data !== 32'hA5) begin mismatched++; $display("FAIL stream_first_data got %0h exp a5", out_data); end
        compared++; if (level !== 2'd1) begin mismatched++; $display("FAIL stream_first_level got %0d exp 1", level); end
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h10 + 32'(i);
            step();
            compared++; if (out_data !== 32'h10 + 32'(i)) begin mismatched++; $display("FAIL stream_data[%0d] got %0h exp %0h", i, out_data, 32'h10 + 32'(i)); end
            compared++; if (level !== 2'd1 || in_ready !== 1'b1) begin mismatched++; $display("FAIL stream_level[%0d] got level %0d ready %0h exp 1/1", i, level, in_ready); end
        end
        in_valid = 1'b0;
        step();
        compared++; if (out_valid !== 1'b0 || level !== 2'd0) begin mismatched++; $display("FAIL stream_drain got valid %0h level %0d exp 0/0", out_valid, level); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
        step();
        compared++; if (level !== 2'd1 || in_ready !== 1'b1 || out_data !== 32'h1) begin mismatched++; $display("FAIL skid_busy got level %0d ready %0h data %0h exp 1/1/1", level, in_ready, out_data); end
        in_data = 32'h2;
        step();
        compared++; if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h1) begin mismatched++; $display("FAIL skid_full got level %0d ready %0h data %0h exp 2/0/1", level, in_ready, out_data); end
        in_data = 32'h3;
        step();
        compared++; if (level !== 2'd2 || out_data !== 32'h1) begin mismatched++; $display("FAIL skid_hold got level %0d data %0h exp 2/1", level, out_data); end
        out_ready = 1'b1;
        step();
        compared++; if (out_data !== 32'h2 || in_ready !== 1'b1 || level !== 2'd1) begin mismatched++; $display("FAIL skid_out2 got data %0h ready %0h level %0d exp 2/1/1", out_data, in_ready, level); end
        step();
        compared++; if (out_data !== 32'h3 || level !== 2'd1) begin mismatched++; $display("FAIL skid_out3 got data %0h level %0d exp 3/1", out_data, level); end
        in_valid = 1'b0;
        step();
        compared++; if (out_valid !== 1'b0 || level !== 2'd0) begin mismatched++; $display("FAIL skid_empty got valid %0h level %0d exp 0/0", out_valid, level); end
    endtask

    task automatic test_clear();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        compared++; if (level !== 2'd2) begin mismatched++; $display("FAIL clear_prefill got level %0d exp 2", level); end
        clear = 1'b1; in_data = 32'h7;
        step();
        clear = 1'b0; in_valid = 1'b0;
        compared++; if (out_valid !== 1'b0 || level !== 2'd0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL clear_state got valid %0h level %0d ready %0h exp 0/0/1", out_valid, level, in_ready); end
        compared++; if (out_data !== 32'h0) begin mismatched++; $display("FAIL clear_data got %0h exp 0", out_data); end
`ifdef SYN_PS_PERF_CNT_EN
        compared++; if (perf_drop_cnt !== 32'd2) begin mismatched++; $display("FAIL clear_drop_cnt got %0d exp 2", perf_drop_cnt); end
`endif
        step();
        compared++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin mismatched++; $display("FAIL clear_beat_discarded got valid %0h data %0h exp 0/0", out_valid, out_data); end
    endtask

    task automatic test_clear_fire();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h33;
        step();
        in_valid = 1'b0;
        compared++; if (level !== 2'd1 || out_data !== 32'h33) begin mismatched++; $display("FAIL clrfire_busy got level %0d data %0h exp 1/33", level, out_data); end
        clear = 1'b1; out_ready = 1'b1;
        step();
        clear = 1'b0;
        compared++; if (level !== 2'd0 || out_valid !== 1'b0) begin mismatched++; $display("FAIL clrfire_empty got level %0d valid %0h exp 0/0", level, out_valid); end
`ifdef SYN_PS_PERF_CNT_EN
        compared++; if (perf_drop_cnt !== 32'd2) begin mismatched++; $display("FAIL clrfire_drop_cnt got %0d exp 2", perf_drop_cnt); end
`endif
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h44;
        step();
        in_data = 32'h55;
        step();
        in_valid = 1'b0;
        compared++; if (level !== 2'd2) begin mismatched++; $display("FAIL areset_prefill got level %0d exp 2", level); end
        #1 rst_n = 1'b0;
        #1;
        compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== 2'd0 || out_data !== 32'h0) begin mismatched++; $display("FAIL areset_immediate got valid %0h ready %0h level %0d data %0h exp 0/1/0/0", out_valid, in_ready, level, out_data); end
        step();
        rst_n = 1'b1;
    endtask

`ifdef SYN_PS_PERF_CNT_EN
    task automatic test_perf();
        rst_n = 1'b0; #1; rst_n = 1'b1;
        compared++; if (perf_stall_cnt !== 32'd0 || perf_drop_cnt !== 32'd0) begin mismatched++; $display("FAIL perf_reset got %0d/%0d exp 0/0", perf_stall_cnt, perf_drop_cnt); end
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h66;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        compared++; if (perf_stall_cnt !== 32'd10) begin mismatched++; $display("FAIL perf_stall got %0d exp 10", perf_stall_cnt); end
        dut.u_stall.cnt_q = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step();
        compared++; if (perf_stall_cnt !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL perf_saturate got %0h exp ffffffff", perf_stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_clear();
        test_clear_fire();
        test_async_reset();
`ifdef SYN_PS_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/syn_ps_elastic.md
# syn_ps_elastic

Parametrised elastic pipeline-stage register for the core pipeline. It replaces the fixed-field `en`/`clear` stage latches with a valid/ready handshake and a 2-entry skid buffer, so back-pressure never combinationally crosses a stage boundary. The payload is an opaque `DATA_W`-bit bundle packed by the instantiating stage. A synchronous flush drops all held beats.

## Interface
- `DATA_W`, 32: payload width in bits, ≥1.
- `ZERO_ON_CLEAR`, 1: 1 = flush also zeroes payload registers; 0 = flush clears valid state only.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clear` input 1: synchronous flush; highest priority after reset.
- `in_valid` input 1: upstream beat valid.
- `in_ready` output 1: stage can accept; registered (decoded from state only).
- `in_data` input DATA_W: upstream payload.
- `out_valid` output 1: downstream beat valid.
- `out_ready` input 1: downstream accepts.
- `out_data` output DATA_W: payload of the head entry (main register).
- `level` output 2: occupancy 0..2.
- `perf_stall_cnt` output 32: (with `SYN_PS_PERF_CNT_EN` only) stall cycles.
- `perf_drop_cnt` output 32: (with `SYN_PS_PERF_CNT_EN` only) beats discarded by `clear`.

## Operation
- Two registers: main (head) and skid. States: EMPTY (0 held), BUSY (main), FULL (main + skid).
- Fire events: `in_fire = in_valid & in_ready`, `out_fire = out_valid & out_ready`.
- `in_ready = (state != FULL)`; `out_valid = (state != EMPTY)`; `level` = 0/1/2 per state.
- EMPTY: `in_fire` loads main and moves to BUSY.
- BUSY:
  - `in_fire & out_fire`: load main, stay BUSY.
  - `in_fire & !out_fire`: load skid, go to FULL.
  - `!in_fire & out_fire`: go to EMPTY.
  - Neither: hold.
- FULL: no input accepted. `out_fire` moves skid to main and goes to BUSY. Otherwise hold.
- `clear`:
  - Next state is EMPTY, regardless of fire events in that cycle.
  - A beat presented on the clear cycle is discarded, even if `in_ready` = 1.
  - `out_fire` on the clear cycle counts as a completed transfer from the downstream side.
  - If `ZERO_ON_CLEAR` = 1, main and skid are zeroed; otherwise their contents are left stale.
- Payload is never reordered. `out_data` changes only on `out_fire`, on `clear` (when `ZERO_ON_CLEAR` = 1), or on a load into an EMPTY stage.

## Timing
- Reset values: state EMPTY; `out_valid` 0; `in_ready` 1; `out_data` 0; skid 0; `level` 0; both perf counters 0.
- Reset asserted mid-transfer: all held beats are lost immediately (asynchronous reset).
- Latency: `in_fire` at edge N gives `out_valid` = 1 after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle sustained while `out_ready` = 1.
- When `out_ready` falls, at most one extra beat is absorbed (into skid). `in_ready` drops in the cycle after the skid fills.
- Recovery: `out_ready` rising in FULL makes `in_ready` = 1 in the next cycle.

## Configuration
- Macro `SYN_PS_PERF_CNT_EN`.
- Defined:
  - `perf_stall_cnt` increments each cycle with `out_valid & !out_ready & !clear`.
  - `perf_drop_cnt` adds `level` + (`in_valid` & `in_ready`) on each `clear` cycle, minus 1 if `out_fire` occurs on that same cycle.
  - Both counters saturate at 2^32−1 and reset only via `rst_n`.
- Undefined: the counters, their logic and both perf ports are absent.

## Structure
- Shared package `syn_ps_pkg`:
  - state enum typedef (EMPTY/BUSY/FULL);
  - `PS_LEVEL_W` = 2;
  - `PS_PERF_CNT_W` = 32.
- Sub-module `syn_ps_perf_cnt`: one saturating counter with increment input; instantiated twice under the macro.

## Test plan
- After reset, `in_valid` = 1 with data 0xA5 and `out_ready` = 1 every cycle: `out_data` = 0xA5 one cycle later, then one beat per cycle, `level` = 1 throughout.
- Stream 0x1, 0x2, 0x3 with `out_ready` = 0: 0x1 in main, 0x2 in skid, `in_ready` = 0, `level` = 2. Raise `out_ready`: outputs 0x1, 0x2, 0x3 in order, none lost or duplicated.
- FULL, then `clear` = 1 with `in_valid` = 1, data 0x7: next cycle `out_valid` = 0, `level` = 0, `in_ready` = 1, `out_data` = 0 (with `ZERO_ON_CLEAR` = 1). With `SYN_PS_PERF_CNT_EN`, `perf_drop_cnt` = 2.
- BUSY, `clear` and `out_ready` both 1 on the same cycle: the beat counts as transferred, the state is EMPTY, and `perf_drop_cnt` is unchanged.
- Deassert `rst_n` while FULL: outputs return to reset values asynchronously, before the next edge.
- With `SYN_PS_PERF_CNT_EN`: hold `out_valid` = 1 and `out_ready` = 0 for 10 cycles gives `perf_stall_cnt` = 10. Preload the counter near its maximum to check it saturates at 0xFFFFFFFF.
